// File: rtl/lightcube_pkg.sv
// Shared constants, state encoding and sizing helper for the light cube scan sequencer.
// States are plain 3-bit constants so older code that compares raw codes keeps working.
package lightcube_pkg;

    localparam int LAYERS = 8;
    localparam int ROWS   = 8;
    localparam int FB_AW  = 6;
    localparam int IDX_W  = 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BLANK   = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_SETUP   = 3'd3;
    localparam logic [2:0] S_STROBE  = 3'd4;
    localparam logic [2:0] S_DISPLAY = 3'd5;

    // Largest of three cycle counts; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lightcube_scan_ctrl_if.sv
// Frame buffer read port plus row/layer drive bus of the scan sequencer.
// The master side is the sequencer; the slave side is the buffer and pin wrapper.
interface lightcube_scan_ctrl_if;
    import lightcube_pkg::*;

    logic                 enable;
    logic                 rd_en;
    logic [FB_AW-1:0]     rd_addr;
    logic [7:0]           rd_data;
    logic [ROWS-1:0]      row;
    logic [ROWS-1:0]      row_cs;
    logic [LAYERS-1:0]    high_csn;
    logic [IDX_W-1:0]     cur_layer;
    logic                 frame_done;

    modport master (
        input  enable,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output row,
        output row_cs,
        output high_csn,
        output cur_layer,
        output frame_done
    );

    modport slave (
        output enable,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  row,
        input  row_cs,
        input  high_csn,
        input  cur_layer,
        input  frame_done
    );

endinterface

// File: rtl/lightcube_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on phase entry makes the phase last exactly N cycles.
module lightcube_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/lightcube_scan_ctrl.sv
// Layer-multiplexed scan sequencer: blank, load eight row latches from the frame
// buffer, then light one layer for a fixed dwell. All outputs come straight from flops.
module lightcube_scan_ctrl #(
    parameter int BLANK_CYC  = 100,
    parameter int STROBE_CYC = 4,
    parameter int DWELL_CYC  = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    lightcube_scan_ctrl_if.master bus
);
    import lightcube_pkg::*;

    localparam int MAX_CYC = max3(BLANK_CYC, STROBE_CYC, DWELL_CYC);
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] BLANK_LD  = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_CYC - 1);
    localparam logic [TW-1:0] DWELL_LD  = TW'(DWELL_CYC - 1);

    localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(LAYERS - 1);

    state_t               state_reg;
    logic [IDX_W-1:0]     layer_reg;
    logic [IDX_W-1:0]     row_idx_reg;
    logic                 rd_en_reg;
    logic [FB_AW-1:0]     rd_addr_reg;
    logic [ROWS-1:0]      row_reg;
    logic [ROWS-1:0]      row_cs_reg;
    logic [LAYERS-1:0]    high_csn_reg;
    logic                 frame_done_reg;

    logic                 timer_load;
    logic [TW-1:0]        timer_val;
    logic                 timer_done;

    logic [ROWS-1:0]      row_sel;
    logic [LAYERS-1:0]    layer_sel;

    // One-hot decodes of the current row and layer indices.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row_sel
            assign row_sel[gi] = (row_idx_reg == IDX_W'(gi));
        end
        for (gi = 0; gi < LAYERS; gi++) begin : g_layer_sel
            assign layer_sel[gi] = (layer_reg == IDX_W'(gi));
        end
    endgenerate

    // Timer is reloaded on entry to each timed phase.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = BLANK_LD;
        if (bus.enable) begin
            case (state_reg)
                S_IDLE: begin
                    timer_load = 1'b1;
                    timer_val  = BLANK_LD;
                end
                S_SETUP: begin
                    timer_load = 1'b1;
                    timer_val  = STROBE_LD;
                end
                S_STROBE: begin
                    if (timer_done && (row_idx_reg == LAST_ROW)) begin
                        timer_load = 1'b1;
                        timer_val  = DWELL_LD;
                    end
                end
                S_DISPLAY: begin
                    if (timer_done) begin
                        timer_load = 1'b1;
                        timer_val  = BLANK_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    lightcube_cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            layer_reg      <= '0;
            row_idx_reg    <= '0;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            row_reg        <= '0;
            row_cs_reg     <= '0;
            high_csn_reg   <= '1;
            frame_done_reg <= 1'b0;
        end else if (!bus.enable) begin
            // Abort from any state, mid-row or mid-dwell.
            state_reg      <= S_IDLE;
            layer_reg      <= '0;
            row_idx_reg    <= '0;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            row_reg        <= '0;
            row_cs_reg     <= '0;
            high_csn_reg   <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            rd_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    state_reg   <= S_BLANK;
                    layer_reg   <= '0;
                    row_idx_reg <= '0;
                end
                S_BLANK: begin
                    row_idx_reg <= '0;
                    if (timer_done) begin
                        state_reg   <= S_FETCH;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= {layer_reg, {IDX_W{1'b0}}};
                    end
                end
                S_FETCH: begin
                    state_reg <= S_SETUP;
                end
                S_SETUP: begin
                    // Row data and its strobe change together; the latch samples on the strobe's fall.
                    row_reg    <= bus.rd_data;
                    row_cs_reg <= row_sel;
                    state_reg  <= S_STROBE;
                end
                S_STROBE: begin
                    if (timer_done) begin
                        row_cs_reg <= '0;
                        if (row_idx_reg == LAST_ROW) begin
                            state_reg    <= S_DISPLAY;
                            high_csn_reg <= ~layer_sel;
                        end else begin
                            state_reg   <= S_FETCH;
                            row_idx_reg <= row_idx_reg + 3'd1;
                            rd_en_reg   <= 1'b1;
                            rd_addr_reg <= {layer_reg, row_idx_reg + 3'd1};
                        end
                    end
                end
                S_DISPLAY: begin
                    if (timer_done) begin
                        high_csn_reg <= '1;
                        state_reg    <= S_BLANK;
                        layer_reg    <= layer_reg + 3'd1;
                        if (layer_reg == LAST_LAYER) begin
                            frame_done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en      = rd_en_reg;
    assign bus.rd_addr    = rd_addr_reg;
    assign bus.row        = row_reg;
    assign bus.row_cs     = row_cs_reg;
    assign bus.high_csn   = high_csn_reg;
    assign bus.cur_layer  = layer_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
